// File: rtl/mac_dot_feeder.sv
// rtl/mac_dot_feeder.sv - operand FIFO and sequencer feeding an 8x8 MAC to compute a dot product; optional watchdog under MAC_FEEDER_WATCHDOG_EN
module mac_dot_feeder #(
    parameter int DEPTH  = 4,   // operand FIFO entries, power of 2, >= 2
    parameter int LEN_W  = 8,   // job length field width
    parameter int SETTLE = 2    // idle cycles after busy falls, >= 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             in_ready,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    output logic             mac_set_b,
    output logic             mac_reset,
    input  logic             mac_busy,
    input  logic [15:0]      mac_o,
    input  logic             mac_overflow,
    output logic             job_busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             result_ovf,
    output logic             error
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE + 1) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;
    localparam logic [2:0] S_SETTLE  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]       state;
    logic [LEN_W-1:0] job_len;
    logic [LEN_W-1:0] count;
    logic [SW-1:0]    settle_cnt;

    logic [7:0]  fifo_a [DEPTH];
    logic [7:0]  fifo_b [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          abort;

    assign full      = (occ == (AW+1)'(DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = (state == S_ISSUE);
    assign mac_set_b = (state == S_ISSUE);
    assign done      = (state == S_DONE);

`ifdef MAC_FEEDER_WATCHDOG_EN
    logic [3:0] wd_cnt;
    logic       abort_q;
    logic       error_q;

    // Counter restarts at ISSUE and again on the first cycle busy is seen high.
    assign abort = ((state == S_WAIT_HI) && !mac_busy && (wd_cnt == 4'd6)) ||
                   ((state == S_WAIT_LO) &&  mac_busy && (wd_cnt == 4'd14));
    assign mac_reset = reset || (state == S_CLEAR) || abort_q;
    assign error     = error_q;

    // Watchdog timer, sticky error flag and the one-cycle MAC clear after an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt  <= '0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            abort_q <= abort;
            if (abort)
                error_q <= 1'b1;
            else if (state == S_IDLE && start)
                error_q <= 1'b0;
            if (state == S_ISSUE || (state == S_WAIT_HI && mac_busy))
                wd_cnt <= '0;
            else if (state == S_WAIT_HI || state == S_WAIT_LO)
                wd_cnt <= wd_cnt + 4'd1;
        end
    end
`else
    assign abort     = 1'b0;
    assign mac_reset = reset || (state == S_CLEAR);
    assign error     = 1'b0;
`endif

    // FIFO storage; written on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wptr] <= in_a;
            fifo_b[wptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy; reset and watchdog abort both flush.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Job sequencer; result is captured on the way into DONE so it is valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            job_len    <= '0;
            count      <= '0;
            settle_cnt <= '0;
            job_busy   <= 1'b0;
            result     <= '0;
            result_ovf <= 1'b0;
            mac_a      <= '0;
            mac_b      <= '0;
        end else if (abort) begin
            state    <= S_IDLE;
            job_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        job_len  <= len;
                        count    <= '0;
                        job_busy <= 1'b1;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (job_len == '0) begin
                        result     <= '0;
                        result_ovf <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!empty && !mac_busy) begin
                        mac_a <= fifo_a[rptr];
                        mac_b <= fifo_b[rptr];
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (mac_busy)
                        state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!mac_busy) begin
                        count      <= count + LEN_W'(1);
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        if (count == job_len) begin
                            result     <= mac_o;
                            result_ovf <= mac_overflow;
                            state      <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_DONE: begin
                    job_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_feeder.sv
// tb/tb_mac_dot_feeder.sv - self-checking bench for mac_dot_feeder with a behavioural MAC
module tb_mac_dot_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_ready;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_set_b;
    logic        mac_reset;
    logic        mac_busy;
    logic [15:0] mac_o;
    logic        mac_overflow;
    logic        job_busy;
    logic        done;
    logic [15:0] result;
    logic        result_ovf;
    logic        error;

    mac_dot_feeder #(.DEPTH(4), .LEN_W(8), .SETTLE(2)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_set_b(mac_set_b), .mac_reset(mac_reset),
        .mac_busy(mac_busy), .mac_o(mac_o), .mac_overflow(mac_overflow),
        .job_busy(job_busy), .done(done), .result(result), .result_ovf(result_ovf),
        .error(error)
    );

    always #5 clk = ~clk;

    // behavioural MAC: busy for 3 cycles after set_b, accumulates when busy falls
    logic        stuck = 1'b0;
    logic        tb_busy = 1'b0;
    logic [1:0]  bcnt = '0;
    logic [7:0]  op_a = '0;
    logic [7:0]  op_b = '0;
    logic [15:0] acc = '0;
    logic        ovf = 1'b0;
    wire signed [15:0] prod = $signed(op_a) * $signed(op_b);
    wire signed [16:0] sum  = $signed({acc[15], acc}) + $signed({prod[15], prod});

    assign mac_busy     = tb_busy;
    assign mac_o        = acc;
    assign mac_overflow = ovf;

    always @(posedge clk) begin
        if (mac_reset) begin
            tb_busy <= 1'b0; bcnt <= '0; acc <= '0; ovf <= 1'b0;
        end else if (mac_set_b && !stuck) begin
            op_a <= mac_a; op_b <= mac_b; tb_busy <= 1'b1; bcnt <= 2'd3;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 2'd1;
            if (bcnt == 2'd1) begin
                tb_busy <= 1'b0;
                acc <= sum[15:0];
                if (sum[16] ^ sum[15]) ovf <= 1'b1;
            end
        end
    end

    int setb_cnt = 0;
    int mrst_cnt = 0;
    int viol = 0;
    logic [15:0] issued[$];

    always @(posedge clk) begin
        if (!reset && mac_reset) mrst_cnt++;
        if (mac_set_b) begin
            setb_cnt++;
            if (tb_busy) viol++;
            issued.push_back({mac_a, mac_b});
        end
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  l;
        logic [15:0] res;
        logic        o;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic [7:0] l, input logic [15:0] r, input logic o);
        vec_t v;
        v.n = n; v.a = a; v.b = b; v.l = l; v.res = r; v.o = o;
        return v;
    endfunction

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic start_job(input logic [7:0] l);
        @(negedge clk);
        start = 1'b1; len = l;
        @(negedge clk);
        start = 1'b0; len = 8'hFF;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int s0, r0;
        bit got;
        v = vecs[i];
        for (int k = 0; k < v.n; k++) push_pair(v.a[8*k +: 8], v.b[8*k +: 8]);
        s0 = setb_cnt; r0 = mrst_cnt;
        start_job(v.l);
        wait_done(got);
        chk($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("v%0d_result", i), 32'(result), 32'(v.res));
            chk($sformatf("v%0d_result_ovf", i), 32'(result_ovf), 32'(v.o));
            chk($sformatf("v%0d_set_b_count", i), 32'(setb_cnt - s0), 32'(v.l));
            chk($sformatf("v%0d_clear_count", i), 32'(mrst_cnt - r0), 32'd1);
            chk($sformatf("v%0d_busy_violations", i), 32'(viol), 32'd0);
            chk($sformatf("v%0d_error", i), 32'(error), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_job_busy_low", i), 32'(job_busy), 32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL sim_time_limit: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit got;
        bit rdy;
        int k, s0, r0, q0, c;

        vecs[0] = mk(2, {8'd0, 8'd0, 8'd2, 8'd3},      {8'd0, 8'd0, 8'd5, 8'd4},      8'd2, 16'h0016, 1'b0);
        vecs[1] = mk(2, {8'd0, 8'd0, 8'd2, 8'hFD},     {8'd0, 8'd0, 8'hFB, 8'd4},     8'd2, 16'hFFEA, 1'b0);
        vecs[2] = mk(3, {8'd0, 8'hFF, 8'd1, 8'h80},    {8'd0, 8'd1, 8'd1, 8'h80},     8'd3, 16'h4000, 1'b0);
        vecs[3] = mk(1, {8'd0, 8'd0, 8'd0, 8'd10},     {8'd0, 8'd0, 8'd0, 8'hF6},     8'd1, 16'hFF9C, 1'b0);
        vecs[4] = mk(4, {4{8'h7F}},                    {4{8'h7F}},                    8'd4, 16'hFC04, 1'b1);

        // reset state
        repeat (2) @(negedge clk);
        chk("mac_reset_in_reset", 32'(mac_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mac_set_b", 32'(mac_set_b), 32'd0);
        chk("rst_mac_a", 32'(mac_a), 32'd0);
        chk("rst_mac_b", 32'(mac_b), 32'd0);
        chk("rst_job_busy", 32'(job_busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_ovf", 32'(result_ovf), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mac_reset", 32'(mac_reset), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // len=0: clear pulse, done next cycle, result and ovf forced to 0
        s0 = setb_cnt;
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_clear_pulse", 32'(mac_reset), 32'd1);
        chk("len0_not_done_yet", 32'(done), 32'd0);
        chk("len0_job_busy", 32'(job_busy), 32'd1);
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_result", 32'(result), 32'd0);
        chk("len0_result_ovf", 32'(result_ovf), 32'd0);
        chk("len0_no_set_b", 32'(setb_cnt - s0), 32'd0);
        @(negedge clk);
        chk("len0_done_pulse", 32'(done), 32'd0);

        // backpressure: six pairs, four fit; the rest drain in order as pops occur
        q0 = issued.size();
        k = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc == 8) begin
                chk("bp_accepted_before_start", 32'(k), 32'd4);
                chk("bp_in_ready_full", 32'(in_ready), 32'd0);
            end
            in_valid = (k < 6); in_a = 8'(k + 1); in_b = 8'(k + 1);
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) k++;
        end
        @(negedge clk);
        start = 1'b1; len = 8'd4;
        in_valid = (k < 6); in_a = 8'(k + 1); in_b = 8'(k + 1);
        rdy = in_ready;
        @(posedge clk);
        if (in_valid && rdy) k++;
        got = 1'b0;
        for (int cc = 0; cc < 400; cc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
            in_valid = (k < 6); in_a = 8'(k + 1); in_b = 8'(k + 1);
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) k++;
        end
        in_valid = 1'b0;
        chk("bp_job1_done", 32'(got), 32'd1);
        chk("bp_job1_result", 32'(result), 32'h1E);
        chk("bp_all_accepted", 32'(k), 32'd6);
        start_job(8'd2);
        wait_done(got);
        chk("bp_job2_done", 32'(got), 32'd1);
        chk("bp_job2_result", 32'(result), 32'h3D);
        for (int j = 0; j < 6; j++) begin
            if (q0 + j < issued.size())
                chk($sformatf("bp_order_%0d", j), 32'(issued[q0 + j]), 32'({8'(j + 1), 8'(j + 1)}));
            else
                chk($sformatf("bp_order_%0d", j), 32'hDEAD, 32'({8'(j + 1), 8'(j + 1)}));
        end

        // reset while waiting for busy to fall, with a pair still queued
        push_pair(8'd7, 8'd7);
        push_pair(8'd9, 8'd9);
        start_job(8'd1);
        got = 1'b0;
        for (int cc = 0; cc < 50; cc++) begin
            if (tb_busy) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_busy_seen", 32'(got), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_job_busy", 32'(job_busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        push_pair(8'd2, 8'd3);
        start_job(8'd1);
        wait_done(got);
        chk("midrst_new_job_done", 32'(got), 32'd1);
        chk("midrst_new_job_result", 32'(result), 32'd6);

        // MAC never raises busy
        stuck = 1'b1;
        push_pair(8'd1, 8'd1);
        start_job(8'd1);
        got = 1'b0;
        for (int cc = 0; cc < 50; cc++) begin
            if (mac_set_b) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("stuck_set_b_seen", 32'(got), 32'd1);
`ifdef MAC_FEEDER_WATCHDOG_EN
        c = 0;
        got = 1'b0;
        for (int cc = 0; cc < 20; cc++) begin
            @(negedge clk);
            c++;
            if (done) got = 1'b1;
            if (error) break;
        end
        chk("wd_error_latency", 32'(c), 32'd8);
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_no_done", 32'(got), 32'd0);
        chk("wd_job_busy", 32'(job_busy), 32'd0);
        chk("wd_in_ready", 32'(in_ready), 32'd1);
        chk("wd_clear_pulse", 32'(mac_reset), 32'd1);
        chk("wd_result_kept", 32'(result), 32'd6);
        @(negedge clk);
        chk("wd_error_held", 32'(error), 32'd1);
        chk("wd_clear_one_cycle", 32'(mac_reset), 32'd0);
        stuck = 1'b0;
        push_pair(8'd2, 8'd2);
        start_job(8'd1);
        chk("wd_error_cleared", 32'(error), 32'd0);
        wait_done(got);
        chk("wd_recover_done", 32'(got), 32'd1);
        chk("wd_recover_result", 32'(result), 32'd4);
`else
        c = 0;
        for (int cc = 0; cc < 30; cc++) begin
            @(negedge clk);
            if (done) c++;
        end
        chk("nowd_error", 32'(error), 32'd0);
        chk("nowd_still_busy", 32'(job_busy), 32'd1);
        chk("nowd_no_done", 32'(c), 32'd0);
        stuck = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("nowd_reset_recovers", 32'(job_busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_dot_feeder.md
Name: mac_dot_feeder

Overview:
- Upstream controller for the 8x8 MAC block. Buffers incoming operand pairs in a small FIFO and clears the MAC at job start.
- Issues one `set_b` load per pair, only while the MAC multiplier is not busy, and tracks busy completion for each product.
- After LEN products, captures the final 16-bit accumulator and the overflow flag as the dot-product result.

Parameters:
- DEPTH, 4, operand FIFO entries (power of 2, >=2)
- LEN_W, 8, width of job-length field
- SETTLE, 2, idle cycles after busy falls before the next issue (lets MAC accumulate on negedge)

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous active-high reset
- start  in  1  begin job; sampled only in IDLE
- len  in  LEN_W  number of operand pairs in the job; latched on start
- in_valid  in  1  operand pair valid
- in_a  in  8  operand A (two's complement)
- in_b  in  8  operand B (two's complement)
- in_ready  out  1  FIFO can accept a pair
- mac_a  out  8  operand A to MAC
- mac_b  out  8  operand B to MAC
- mac_set_b  out  1  one-cycle load strobe to MAC
- mac_reset  out  1  clear strobe to MAC accumulator
- mac_busy  in  1  MAC multiplier busy
- mac_o  in  16  MAC accumulator value
- mac_overflow  in  1  MAC overflow flag
- job_busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; result is valid
- result  out  16  captured dot product
- result_ovf  out  1  captured overflow
- error  out  1  watchdog abort (feature only; tied 0 otherwise)

Behaviour:
- Reset values: FIFO empty, state IDLE, count 0.
  - in_ready=1, mac_set_b=0, mac_a=mac_b=0.
  - job_busy=0, done=0, result=0, result_ovf=0, error=0.
  - mac_reset = reset OR clear-state strobe, so the MAC clears whenever the feeder resets.
- FIFO:
  - Push on in_valid & in_ready, in any state.
  - in_ready = !full, computed from registered occupancy. A pop and a push in the same cycle while full does not push.
  - Pop occurs only in ISSUE. FIFO order is preserved.
- FSM:
  - IDLE: on start, latch len, set count=0 and job_busy=1, go to CLEAR. Otherwise stay.
  - CLEAR (1 cycle): mac_reset=1.
    - If len==0, go to DONE with result forced to 0 and result_ovf forced to 0.
    - Else go to LOAD.
  - LOAD: wait for FIFO not empty and mac_busy==0, then go to ISSUE.
  - ISSUE (1 cycle): drive mac_a/mac_b from the FIFO head, mac_set_b=1, pop, go to WAIT_HI.
    - mac_a/mac_b hold their value until the next ISSUE.
  - WAIT_HI: wait for mac_busy==1, then go to WAIT_LO.
  - WAIT_LO: wait for mac_busy==0, then count++ and go to SETTLE.
  - SETTLE: SETTLE cycles.
    - If count==len, go to DONE.
    - Else go to LOAD.
  - DONE (1 cycle): result<=mac_o, result_ovf<=mac_overflow, done=1, job_busy<=0, go to IDLE.
- result and result_ovf hold until the next DONE.
- start asserted while not in IDLE is ignored. len changes mid-job are ignored.
- Minimum per-pair latency: ISSUE + busy high + busy low + SETTLE cycles.
- Reset mid-operation: state returns to IDLE and the FIFO is flushed (pairs already stored are discarded). The MAC is cleared via mac_reset. result is zeroed.
- Arithmetic is done entirely by the MAC. The feeder does no width extension and no saturation.

Optional Feature:
- Macro: MAC_FEEDER_WATCHDOG_EN
- With the macro defined:
  - 4-bit timeout counter, active in WAIT_HI and WAIT_LO.
  - If mac_busy fails to rise within 8 cycles of ISSUE, or stays high for more than 15 cycles, the feeder:
    - goes to IDLE;
    - asserts error=1, held until the next accepted start or reset;
    - pulses mac_reset for one cycle;
    - flushes the FIFO;
    - leaves done at 0 and result unchanged.
- Without the macro: no counter, error tied to 0, the FSM waits indefinitely.

Test Plan:
- Basic job: push (3,4),(2,5), len=2, start → one CLEAR pulse, two set_b pulses each issued only after busy=0, done pulse with result=0x0016 and result_ovf=0.
- Signed operands: pairs (-3,4),(2,-5), len=2 → result=0xFFEA (-22).
- Backpressure: push 6 pairs with DEPTH=4 and no start → in_ready drops after 4 accepted. After start with len=4, the remaining pushes are accepted as pops occur, in order.
- len=0 with start → mac_reset pulse, done one cycle later, result=0, no set_b.
- Reset mid-job: reset asserted in WAIT_LO → next cycle state IDLE, in_ready=1, FIFO empty, result=0, job_busy=0. A new job then completes correctly.
- Watchdog, with macro: mac_busy held 0 after ISSUE → error=1 eight cycles later, done stays 0. Without the macro: FSM remains in WAIT_HI and error=0.
